// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity encoding, FSM states and
// the data-bits decode used when a frame starts.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_ODD      = 2'b01,
    PAR_EVEN     = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // 0..4 -> 5..9 data bits; the upper codes saturate at 9.
  function automatic logic [3:0] frame_bits(input logic [2:0] size_frame);
    if (size_frame <= 3'd4) frame_bits = {1'b0, size_frame} + 4'd5;
    else                    frame_bits = 4'd9;
  endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead receive FIFO with wrap-bit pointers; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_drop    = i_push && o_full && !i_pop;
  // Gated so the head reads as zero whenever nothing valid is stored.
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/recv_block.sv
// Oversampling UART receiver feeding a show-ahead FIFO.
// Define RECV_ERR_FLAGS_EN to store parity/framing error flags with each word.
//
// state     | meaning
// ST_IDLE   | line idle, waiting for a low sample while enabled
// ST_START  | confirming the start bit at its midpoint
// ST_DATA   | sampling data bits, LSB first
// ST_PARITY | sampling the parity bit (odd/even modes only)
// ST_STOP   | sampling one or two stop bits, push on the last
module recv_block
  import uart_pkg::*;
#(
  parameter int SIZE_DATA     = 9,
  parameter int OVER_SAMPLING = 16,
  parameter int SIZE_BAUD     = 24,
  parameter int SIZE_DEPTH    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_en,
  input  logic                 i_en_rd,
  input  logic                 i_clr_err,
  input  logic [2:0]           i_size_frame,
  input  logic [1:0]           i_parity_bit,
  input  logic                 i_stop_bit,
  input  logic                 i_data_rx,
  input  logic [SIZE_BAUD-1:0] i_baud_value,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_fifo_empty,
  output logic                 o_fifo_full,
  output logic                 o_overrun
);

  localparam int W_TICK = $clog2(OVER_SAMPLING);
  localparam logic [W_TICK-1:0]    TICK_MID  = W_TICK'(OVER_SAMPLING/2 - 1);
  localparam logic [W_TICK-1:0]    TICK_LAST = W_TICK'(OVER_SAMPLING - 1);
  localparam logic [W_TICK-1:0]    TICK_ONE  = W_TICK'(1);
  localparam logic [SIZE_BAUD-1:0] BAUD_ONE  = SIZE_BAUD'(1);
  localparam logic [3:0]           MAX_BITS  = 4'(SIZE_DATA);
`ifdef RECV_ERR_FLAGS_EN
  localparam int W_WORD = SIZE_DATA + 2;
`else
  localparam int W_WORD = SIZE_DATA;
`endif

  logic [1:0]           r_sync;
  state_e               r_state;
  state_e               w_next;
  logic [SIZE_BAUD-1:0] r_baud;
  logic [SIZE_BAUD-1:0] r_baud_cnt;
  logic [W_TICK-1:0]    r_tick_cnt;
  logic [3:0]           r_nbits;
  logic [3:0]           r_bit_cnt;
  parity_e              r_parity;
  logic                 r_two_stop;
  logic                 r_stop_cnt;
  logic [SIZE_DATA-1:0] r_shift;
  logic                 r_overrun;
  logic                 w_rx;
  logic                 w_tick;
  logic                 w_sample;
  logic                 w_par_on;
  logic                 w_push;
  logic                 w_start;
  logic                 w_drop;
  logic [3:0]           w_nbits_cfg;
  logic [W_WORD-1:0]    w_wdata;
  logic [W_WORD-1:0]    w_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_data_rx};
  end

  assign w_rx        = r_sync[1];
  assign w_tick      = (r_state != ST_IDLE) && (r_baud_cnt == r_baud);
  assign w_sample    = w_tick &&
                       (r_tick_cnt == ((r_state == ST_START) ? TICK_MID : TICK_LAST));
  assign w_par_on    = (r_parity == PAR_ODD) || (r_parity == PAR_EVEN);
  assign w_start     = (r_state == ST_IDLE) && (w_next == ST_START);
  assign w_nbits_cfg = (frame_bits(i_size_frame) > MAX_BITS) ? MAX_BITS
                                                              : frame_bits(i_size_frame);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    case (r_state)
      ST_IDLE:   if (!w_rx) w_next = ST_START;
      ST_START:  if (w_sample) w_next = w_rx ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_sample && (r_bit_cnt == r_nbits - 4'd1))
                   w_next = w_par_on ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_sample) w_next = ST_STOP;
      ST_STOP:   if (w_sample && (r_stop_cnt || !r_two_stop)) begin
                   w_next = ST_IDLE;
                   w_push = 1'b1;
                 end
      default:   w_next = ST_IDLE;
    endcase
    if (!i_rx_en) begin
      w_next = ST_IDLE;
      w_push = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_baud     <= '0;
      r_baud_cnt <= '0;
      r_tick_cnt <= '0;
      r_nbits    <= '0;
      r_bit_cnt  <= '0;
      r_parity   <= PAR_NONE;
      r_two_stop <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
    end else if (r_state == ST_IDLE) begin
      r_baud_cnt <= '0;
      r_tick_cnt <= '0;
      if (w_start) begin
        // Frame format is frozen here for the rest of the frame.
        r_baud     <= i_baud_value;
        r_nbits    <= w_nbits_cfg;
        r_parity   <= parity_e'(i_parity_bit);
        r_two_stop <= i_stop_bit;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
        r_shift    <= '0;
      end
    end else begin
      if (w_tick) begin
        r_baud_cnt <= '0;
        r_tick_cnt <= w_sample ? '0 : r_tick_cnt + TICK_ONE;
      end else begin
        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
      end
      if (w_sample && (r_state == ST_DATA)) begin
        r_shift[r_bit_cnt] <= w_rx;
        r_bit_cnt          <= r_bit_cnt + 4'd1;
      end
      if (w_sample && (r_state == ST_STOP)) r_stop_cnt <= 1'b1;
    end
  end

`ifdef RECV_ERR_FLAGS_EN
  logic r_par_err;
  logic r_frame_err;
  logic w_exp_par;
  logic w_frame_err_fin;

  assign w_exp_par       = (r_parity == PAR_ODD) ? ~^r_shift : ^r_shift;
  assign w_frame_err_fin = r_frame_err | ~w_rx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (w_start) begin
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (w_sample && (r_state == ST_PARITY)) begin
      r_par_err   <= (w_rx != w_exp_par);
    end else if (w_sample && (r_state == ST_STOP)) begin
      r_frame_err <= w_frame_err_fin;
    end
  end

  assign w_wdata      = {w_frame_err_fin, r_par_err, r_shift};
  assign o_parity_err = w_rdata[SIZE_DATA];
  assign o_frame_err  = w_rdata[SIZE_DATA+1];
`else
  assign w_wdata      = r_shift;
  assign o_parity_err = 1'b0;
  assign o_frame_err  = 1'b0;
`endif

  assign o_data = w_rdata[SIZE_DATA-1:0];

  fifo #(
    .WIDTH (W_WORD),
    .DEPTH (SIZE_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (i_en_rd),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_empty (o_fifo_empty),
    .o_full  (o_fifo_full),
    .o_drop  (w_drop)
  );

  // A fresh drop outranks a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_overrun <= 1'b0;
    else if (w_drop)    r_overrun <= 1'b1;
    else if (i_clr_err) r_overrun <= 1'b0;
  end

  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_recv_block.sv
// Self-checking bench for recv_block: serial frames built from the frame
// rules, expected words kept in a queue and compared at the FIFO head.
module tb_recv_block;

  localparam int SD  = 9;
  localparam int OS  = 16;
  localparam int SB  = 24;
  localparam int DEP = 16;
`ifdef RECV_ERR_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic          i_clk;
  logic          i_rst_n;
  logic          i_rx_en;
  logic          i_en_rd;
  logic          i_clr_err;
  logic [2:0]    i_size_frame;
  logic [1:0]    i_parity_bit;
  logic          i_stop_bit;
  logic          i_data_rx;
  logic [SB-1:0] i_baud_value;
  logic [SD-1:0] o_data;
  logic          o_parity_err;
  logic          o_frame_err;
  logic          o_fifo_empty;
  logic          o_fifo_full;
  logic          o_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] exp_q[$];

  recv_block #(
    .SIZE_DATA     (SD),
    .OVER_SAMPLING (OS),
    .SIZE_BAUD     (SB),
    .SIZE_DEPTH    (DEP)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx_en      (i_rx_en),
    .i_en_rd      (i_en_rd),
    .i_clr_err    (i_clr_err),
    .i_size_frame (i_size_frame),
    .i_parity_bit (i_parity_bit),
    .i_stop_bit   (i_stop_bit),
    .i_data_rx    (i_data_rx),
    .i_baud_value (i_baud_value),
    .o_data       (o_data),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_fifo_empty (o_fifo_empty),
    .o_fifo_full  (o_fifo_full),
    .o_overrun    (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic set_cfg(input int sz, input int par, input bit two, input int baud);
    i_size_frame = 3'(sz);
    i_parity_bit = 2'(par);
    i_stop_bit   = two;
    i_baud_value = SB'(baud);
  endtask

  // Drives one complete frame and records the word it should produce.
  task automatic send_frame(input logic [8:0] d, input int sz, input int par,
                            input bit bad_par, input bit two, input bit s1,
                            input bit s2, input int baud);
    int          nb;
    int          k;
    int          per;
    logic [9:0]  mask;
    logic [8:0]  dm;
    logic        pbit;
    logic        pe;
    logic        fe;
    logic        bits[13];
    set_cfg(sz, par, two, baud);
    cycles(2);
    nb   = (sz <= 4) ? sz + 5 : 9;
    mask = (10'd1 << nb) - 10'd1;
    dm   = d & mask[8:0];
    bits[0] = 1'b0;
    for (int i = 0; i < nb; i++) bits[1+i] = dm[i];
    k  = 1 + nb;
    pe = 1'b0;
    if (par == 1 || par == 2) begin
      pbit = (par == 1) ? ~^dm : ^dm;
      if (bad_par) pbit = ~pbit;
      pe = bad_par;
      bits[k] = pbit;
      k++;
    end
    bits[k] = s1;
    k++;
    if (two) begin
      bits[k] = s2;
      k++;
    end
    fe  = !s1 || (two && !s2);
    per = (baud + 1) * OS;
    for (int b = 0; b < k; b++) begin
      i_data_rx = bits[b];
      cycles(per);
    end
    i_data_rx = 1'b1;
    cycles(3 * per);
    exp_q.push_back({fe & FLAGS_ON, pe & FLAGS_ON, dm});
  endtask

  task automatic read_check(input string tag);
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, 32'(o_fifo_empty), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_nonempty"}, 32'(o_fifo_empty), 32'd0);
    chk({tag, "_data"},     32'(o_data),       32'(e[8:0]));
    chk({tag, "_perr"},     32'(o_parity_err), 32'(e[9]));
    chk({tag, "_ferr"},     32'(o_frame_err),  32'(e[10]));
    i_en_rd = 1'b1;
    cycles(1);
    i_en_rd = 1'b0;
  endtask

  initial begin
    logic       lbits[10];
    logic [7:0] d8;
    i_rst_n   = 1'b0;
    i_rx_en   = 1'b1;
    i_en_rd   = 1'b0;
    i_clr_err = 1'b0;
    i_data_rx = 1'b1;
    set_cfg(3, 0, 1'b0, 0);
    cycles(3);
    chk("rst_empty",   32'(o_fifo_empty), 32'd1);
    chk("rst_full",    32'(o_fifo_full),  32'd0);
    chk("rst_overrun", 32'(o_overrun),    32'd0);
    chk("rst_data",    32'(o_data),       32'd0);
    chk("rst_perr",    32'(o_parity_err), 32'd0);
    chk("rst_ferr",    32'(o_frame_err),  32'd0);
    i_rst_n = 1'b1;
    cycles(5);

    // 8N1 0x5A at baud 0: stop sample lands on edge 155 after the start edge.
    d8 = 8'h5A;
    lbits[0] = 1'b0;
    for (int i = 0; i < 8; i++) lbits[1+i] = d8[i];
    lbits[9] = 1'b1;
    set_cfg(3, 0, 1'b0, 0);
    cycles(4);
    for (int c = 0; c < 160; c++) begin
      i_data_rx = lbits[c/16];
      cycles(1);
      if (c + 1 == 154) chk("t040_before", 32'(o_fifo_empty), 32'd1);
      if (c + 1 == 155) chk("t040_after",  32'(o_fifo_empty), 32'd0);
    end
    i_data_rx = 1'b1;
    cycles(32);
    exp_q.push_back({2'b00, 9'h05A});
    read_check("t040");

    send_frame(9'h035, 2, 2, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    read_check("t041");

    send_frame(9'h0C3, 3, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    read_check("t042");

    // Short glitch must be rejected as a false start.
    i_data_rx = 1'b0;
    cycles(3);
    i_data_rx = 1'b1;
    cycles(40);
    chk("glitch_empty", 32'(o_fifo_empty), 32'd1);

    i_en_rd = 1'b1;
    cycles(1);
    i_en_rd = 1'b0;
    chk("pop_empty", 32'(o_fifo_empty), 32'd1);

    // Disable mid-frame: the partial word is discarded.
    set_cfg(3, 0, 1'b0, 1);
    cycles(2);
    i_data_rx = 1'b0;
    cycles(3 * 32);
    i_rx_en   = 1'b0;
    i_data_rx = 1'b1;
    cycles(2);
    i_rx_en = 1'b1;
    cycles(96);
    chk("rxen_empty", 32'(o_fifo_empty), 32'd1);
    send_frame(9'h017, 3, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    read_check("rxen_next");

    for (int n = 0; n < 20; n++) begin
      send_frame(9'($urandom_range(0, 511)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 4) != 0), int'($urandom_range(0, 3)));
      read_check($sformatf("rnd%0d", n));
    end

    // Fill to depth, then one more to overflow.
    for (int n = 0; n < 16; n++)
      send_frame(9'(n * 7 + 3), 3, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    chk("ovr_full16",  32'(o_fifo_full), 32'd1);
    chk("ovr_clear16", 32'(o_overrun),   32'd0);
    send_frame(9'h0EE, 3, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    void'(exp_q.pop_back());
    chk("ovr_full17", 32'(o_fifo_full), 32'd1);
    chk("ovr_set",    32'(o_overrun),   32'd1);
    for (int n = 0; n < 16; n++) read_check($sformatf("ovr%0d", n));
    chk("ovr_drained", 32'(o_fifo_empty), 32'd1);
    chk("ovr_sticky",  32'(o_overrun),    32'd1);
    i_clr_err = 1'b1;
    cycles(1);
    i_clr_err = 1'b0;
    chk("ovr_cleared", 32'(o_overrun), 32'd0);

    // Async reset in the middle of a data bit with a word already buffered.
    send_frame(9'h033, 3, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    chk("r045_buffered", 32'(o_fifo_empty), 32'd0);
    set_cfg(3, 0, 1'b0, 0);
    cycles(2);
    i_data_rx = 1'b0;
    cycles(16 * 3);
    #3 i_rst_n = 1'b0;
    #1;
    chk("r045_empty", 32'(o_fifo_empty), 32'd1);
    chk("r045_data",  32'(o_data),       32'd0);
    chk("r045_full",  32'(o_fifo_full),  32'd0);
    exp_q.delete();
    i_data_rx = 1'b1;
    #1 i_rst_n = 1'b1;
    cycles(20);
    send_frame(9'h0A5, 3, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    read_check("r045_next");
    chk("final_empty", 32'(o_fifo_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/recv_block.md
RECV_BLOCK -- requirements
Module: recv_block

Interface
REQ-001 Parameter SIZE_DATA, default 9: maximum data bits per frame and width of o_data.
REQ-002 Parameter OVER_SAMPLING, default 16: baud ticks per bit.
REQ-003 Parameter SIZE_BAUD, default 24: width of i_baud_value.
REQ-004 Parameter SIZE_DEPTH, default 16: receive FIFO depth in words, power of two.
REQ-005 Port i_clk, input, 1: the single clock; all logic is rising-edge triggered.
REQ-006 Port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port i_rx_en, input, 1: receiver enable.
REQ-008 Port i_en_rd, input, 1: pop one word from the FIFO.
REQ-009 Port i_clr_err, input, 1: clear the sticky overrun flag.
REQ-010 Port i_size_frame, input, 3: data bits; 0..4 select 5..9 bits, 5..7 select 9 bits.
REQ-011 Port i_parity_bit, input, 2: 00 none, 01 odd, 10 even, 11 none.
REQ-012 Port i_stop_bit, input, 1: 0 selects one stop bit, 1 selects two.
REQ-013 Port i_data_rx, input, 1: asynchronous serial line, idle high.
REQ-014 Port i_baud_value, input, SIZE_BAUD: tick divisor.
REQ-015 Port o_data, output, SIZE_DATA: FIFO head data, right-aligned, unused MSBs 0.
REQ-016 Port o_parity_err, output, 1: parity error flag of the FIFO head word.
REQ-017 Port o_frame_err, output, 1: framing error flag of the FIFO head word.
REQ-018 Port o_fifo_empty, output, 1: FIFO holds no words.
REQ-019 Port o_fifo_full, output, 1: FIFO holds SIZE_DEPTH words.
REQ-020 Port o_overrun, output, 1: sticky flag, a completed word was dropped.

Function
REQ-021 i_data_rx shall pass through a 2-flop synchronizer before any use.
REQ-022 The tick counter shall run 0..i_baud_value and pulse one tick on the cycle it equals i_baud_value, giving a tick period of i_baud_value+1 clocks.
REQ-023 The FSM shall have states IDLE, START, DATA, PARITY, STOP.
REQ-024 IDLE -> START on the first synchronized low sample while i_rx_en=1; the tick count is cleared on entry.
REQ-025 START shall resample at tick OVER_SAMPLING/2-1; high -> IDLE (false start, nothing pushed), low -> DATA.
REQ-026 DATA, PARITY and STOP shall sample once every OVER_SAMPLING ticks after the start midpoint; data is LSB first.
REQ-027 PARITY is entered only when parity is odd or even; parity_err = received parity differs from the computed parity over the received data bits.
REQ-028 frame_err = any sampled stop bit low; with two stop bits, both are sampled.
REQ-029 The word {frame_err, parity_err, data} shall be pushed on the final stop-sample cycle; the FSM returns to IDLE on that cycle, and o_fifo_empty falls on the next cycle.
REQ-030 A push while full without a same-cycle pop shall drop the word and set o_overrun; push and pop in the same cycle while full shall both succeed.
REQ-031 A pop while empty shall be ignored; o_data, o_parity_err and o_frame_err are show-ahead and valid whenever o_fifo_empty=0.
REQ-032 i_clr_err=1 shall clear o_overrun on the next cycle; a simultaneous new overrun takes priority.
REQ-033 i_rx_en=0 shall force IDLE on the next cycle and discard the partial frame; the FIFO contents are kept.
REQ-034 Configuration inputs shall be sampled when leaving IDLE and held for the whole frame.

Reset
REQ-035 While i_rst_n=0: FSM is in IDLE, counters are 0, the synchronizer is 1, FIFO pointers are 0, o_fifo_empty=1, and all other outputs are 0.

Configuration
REQ-036 Macro RECV_ERR_FLAGS_EN: when defined, FIFO words are SIZE_DATA+2 bits and carry the error flags.
REQ-037 Without RECV_ERR_FLAGS_EN: FIFO words are SIZE_DATA bits, o_parity_err and o_frame_err are tied 0, and the parity and stop bits are still consumed; o_overrun is unaffected.

Structure
REQ-038 Package uart_pkg shall hold the parity encoding enum, the FSM state enum and the frame-size decode function.
REQ-039 One sub-module, fifo, shall be instantiated for the receive buffer; the synchronizer, tick counter and FSM are implemented inline.

Verification
REQ-040 baud_value=0, 8N1, frame 0x5A -> o_data=0x5A with both error flags 0; o_fifo_empty falls 1 cycle after the stop-bit sample.
REQ-041 7-bit even parity, data 0x35 sent with a wrong parity bit -> o_data=0x35, o_parity_err=1.
REQ-042 8N2, second stop bit driven low -> o_frame_err=1, word still pushed.
REQ-043 A 3-clock low glitch on an idle line with baud_value=0 -> nothing pushed, FSM back in IDLE.
REQ-044 17 frames with no reads -> o_fifo_full=1 and o_overrun=1; the first 16 words are intact; i_clr_err=1 clears o_overrun.
REQ-045 i_rst_n pulsed low mid-DATA -> outputs reach reset values immediately; the next clean frame 0xA5 is received correctly.
